// File: rtl/time_bcd_display_if.sv
// Bundle between the time counter stage and the BCD display block:
// binary count in, BCD result, status and segment/digit drive out.
interface time_bcd_display_if;
  logic [7:0]  time_counter;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (
    output time_counter,
    input  bcd, bcd_valid, busy, seg, an
  );

  modport slave (
    input  time_counter,
    output bcd, bcd_valid, busy, seg, an
  );
endinterface

// File: rtl/time_bcd_display.sv
// Binary-to-BCD (shift-add-3) on every counter change, 10 edges capture-to-result, no backpressure
// (changes during a conversion are picked up on return to IDLE); drives a scanned 3-digit 7-seg.
module time_bcd_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic          clock,
  input  logic          reset_start,
  time_bcd_display_if.slave io
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q,    state_d;
  logic [7:0]  last_val_q, last_val_d;
  logic        first_q,    first_d;
  logic [7:0]  sh_bin_q,   sh_bin_d;
  logic [11:0] scratch_q,  scratch_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [11:0] bcd_q,      bcd_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  an_q,       an_d;

  logic [11:0] adj;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  seg;

  function automatic logic [11:0] add3(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Conversion FSM: capture, eight add-3/shift steps, then publish.
  always_comb begin
    state_d     = state_q;
    last_val_d  = last_val_q;
    first_d     = first_q;
    sh_bin_d    = sh_bin_q;
    scratch_d   = scratch_q;
    bit_cnt_d   = bit_cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    adj         = add3(scratch_q);
    case (state_q)
      IDLE: begin
        if ((io.time_counter != last_val_q) || first_q) begin
          state_d    = SHIFT;
          sh_bin_d   = io.time_counter;
          last_val_d = io.time_counter;
          scratch_d  = 12'd0;
          bit_cnt_d  = 3'd0;
          first_d    = 1'b0;
        end
      end
      SHIFT: begin
        scratch_d = {adj[10:0], sh_bin_q[7]};
        sh_bin_d  = {sh_bin_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d       = scratch_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan free-runs regardless of conversion state.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    an_d       = an_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      an_d       = {an_q[1:0], an_q[2]};
    end
  end

  // Leading-zero blanking on hundreds and tens; ones always shown once valid.
  always_comb begin
    digit = bcd_q[3:0];
    blank = !bcd_valid_q;
    case (an_q)
      3'b001: digit = bcd_q[3:0];
      3'b010: begin
        digit = bcd_q[7:4];
        if ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) blank = 1'b1;
      end
      3'b100: begin
        digit = bcd_q[11:8];
        if (bcd_q[11:8] == 4'd0) blank = 1'b1;
      end
      default: blank = 1'b1;
    endcase
    seg = blank ? 7'h00 : decode(digit);
  end

  always_ff @(posedge clock or posedge reset_start) begin
    if (reset_start) begin
      state_q     <= IDLE;
      last_val_q  <= 8'd0;
      first_q     <= 1'b1;
      sh_bin_q    <= 8'd0;
      scratch_q   <= 12'd0;
      bit_cnt_q   <= 3'd0;
      bcd_q       <= 12'd0;
      bcd_valid_q <= 1'b0;
      scan_cnt_q  <= 16'd0;
      an_q        <= 3'b001;
    end else begin
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      first_q     <= first_d;
      sh_bin_q    <= sh_bin_d;
      scratch_q   <= scratch_d;
      bit_cnt_q   <= bit_cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      an_q        <= an_d;
    end
  end

  assign io.bcd       = bcd_q;
  assign io.bcd_valid = bcd_valid_q;
  assign io.busy      = (state_q != IDLE);
  assign io.seg       = seg;
  assign io.an        = an_q;

endmodule

// File: tb/tb_time_bcd_display.sv
// Directed bench for time_bcd_display: conversion latency, blanking, scan cadence,
// mid-conversion input change, async reset and a full 0..255 sweep.
module tb_time_bcd_display;

  logic clock;
  logic reset_start;
  int   n_tests;
  int   n_fail;
  int   n_edge;

  time_bcd_display_if bus ();

  time_bcd_display #(.SCAN_DIV(4)) dut (
    .clock       (clock),
    .reset_start (reset_start),
    .io          (bus)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    n_edge++;
  endtask

  function automatic logic [2:0] an_exp();
    logic [2:0] a;
    a = 3'b001 << ((n_edge / 4) % 3);
    return a;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  // Twelve cycles covers one full scan round at SCAN_DIV=4.
  task automatic scan_chk(input string tag, input logic [6:0] s1, input logic [6:0] s2,
                          input logic [6:0] s4);
    logic [2:0] ea;
    logic [6:0] es;
    for (int i = 0; i < 12; i++) begin
      tick();
      ea = an_exp();
      es = (ea == 3'b001) ? s1 : (ea == 3'b010) ? s2 : s4;
      chk({tag, "_an"}, 32'(bus.an), 32'(ea));
      chk({tag, "_seg"}, 32'(bus.seg), 32'(es));
    end
  endtask

  // Drive a new value and check busy/bcd at the exact latency boundary.
  task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] prev);
    bus.time_counter = v;
    repeat (9) tick();
    chk({tag, "_busy9"}, 32'(bus.busy), 32'd1);
    chk({tag, "_bcd9"}, 32'(bus.bcd), 32'(prev));
    tick();
    chk({tag, "_busy10"}, 32'(bus.busy), 32'd0);
    chk({tag, "_bcd10"}, 32'(bus.bcd), 32'(to_bcd(int'(v))));
  endtask

  initial begin
    int busy_cnt;
    bit bad_valid;
    bit bad_nib;
    n_tests = 0;
    n_fail = 0;
    n_edge = 0;
    bus.time_counter = 8'd0;
    reset_start = 1'b1;
    #25;
    reset_start = 1'b0;

    // 1: reset state, first conversion of 0
    chk("rst_bcd", 32'(bus.bcd), 32'h000);
    chk("rst_valid", 32'(bus.bcd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_an", 32'(bus.an), 32'b001);
    chk("rst_seg", 32'(bus.seg), 32'h00);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy) busy_cnt++;
    end
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("t1_bcd", 32'(bus.bcd), 32'h000);
    chk("t1_valid", 32'(bus.bcd_valid), 32'd1);
    scan_chk("t1", 7'h3F, 7'h00, 7'h00);

    // 2: 255
    convert("t2", 8'd255, 12'h000);
    scan_chk("t2", 7'h6D, 7'h6D, 7'h5B);

    // 3: 9 then 10
    convert("t3a", 8'd9, 12'h255);
    scan_chk("t3a", 7'h6F, 7'h00, 7'h00);
    convert("t3b", 8'd10, 12'h009);
    scan_chk("t3b", 7'h3F, 7'h06, 7'h00);

    // 4: change to 101 three cycles into the 100 conversion
    bus.time_counter = 8'd100;
    repeat (4) tick();
    bus.time_counter = 8'd101;
    repeat (6) tick();
    chk("t4_bcd100", 32'(bus.bcd), 32'h100);
    chk("t4_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("t4_rebusy", 32'(bus.busy), 32'd1);
    repeat (8) tick();
    chk("t4_bcd_hold", 32'(bus.bcd), 32'h100);
    tick();
    chk("t4_bcd101", 32'(bus.bcd), 32'h101);
    chk("t4_busy_end", 32'(bus.busy), 32'd0);

    // 5: async reset mid-conversion of 200
    bus.time_counter = 8'd200;
    repeat (4) tick();
    chk("t5_busy_mid", 32'(bus.busy), 32'd1);
    #2;
    reset_start = 1'b1;
    #1;
    chk("t5_rst_bcd", 32'(bus.bcd), 32'h000);
    chk("t5_rst_valid", 32'(bus.bcd_valid), 32'd0);
    chk("t5_rst_an", 32'(bus.an), 32'b001);
    chk("t5_rst_seg", 32'(bus.seg), 32'h00);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_start = 1'b0;
    n_edge = 0;
    convert("t5", 8'd200, 12'h000);
    chk("t5_valid", 32'(bus.bcd_valid), 32'd1);
    scan_chk("t5", 7'h3F, 7'h3F, 7'h5B);

    // 6: full up-count sweep, 20 cycles per value
    bad_valid = 1'b0;
    bad_nib = 1'b0;
    for (int v = 0; v < 256; v++) begin
      bus.time_counter = 8'(v);
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.bcd_valid !== 1'b1) bad_valid = 1'b1;
        if (bus.bcd[3:0] > 4'd9 || bus.bcd[7:4] > 4'd9 || bus.bcd[11:8] > 4'd9) bad_nib = 1'b1;
        if (c == 9) chk($sformatf("t6_bcd_%0d", v), 32'(bus.bcd), 32'(to_bcd(v)));
      end
    end
    chk("t6_valid_sticky", 32'(bad_valid), 32'd0);
    chk("t6_nibble_range", 32'(bad_nib), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
